// File: rtl/led_pio_pkg.sv
// Shared types and constants for the LED PIO arbiter slice.
package led_pio_pkg;

  localparam int unsigned LED_DATA_W    = 5;
  localparam int unsigned PIO_BUS_W     = 32;
  localparam logic [1:0]  LED_ADDR_DATA = 2'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    HOLD   = 2'd3
  } led_state_e;

endpackage

// File: rtl/led_rr_arbiter2.sv
// Two-way round-robin grant; purely combinational, owner of last_grant lives in the top.
module led_rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_any_c,
  output logic grant_idx_c
);

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_any_c = valid0 | valid1;
    grant_idx_c = 1'b0;
    if (valid0 && valid1) begin
      grant_idx_c = ~last_grant;
    end else if (valid1) begin
      grant_idx_c = 1'b1;
    end
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Avalon-MM master sharing the LED PIO between two pattern requesters:
// round-robin accept, one write, read-back verify, then a minimum display hold.
module led_pio_arbiter
  import led_pio_pkg::*;
#(
  parameter int unsigned DATA_W      = LED_DATA_W,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned CNT_W       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic [1:0]           pio_address,
  output logic                 pio_chipselect,
  output logic                 pio_write_n,
  output logic [PIO_BUS_W-1:0] pio_writedata,
  input  logic [PIO_BUS_W-1:0] pio_readdata,
  output logic                 busy,
  output logic                 last_grant,
  output logic [DATA_W-1:0]    current_pattern,
  output logic                 verify_err,
  input  logic                 err_clear
);

  led_state_e        state;
  logic [DATA_W-1:0] pattern_q;
  logic [CNT_W-1:0]  hold_cnt;
  logic              grant_any_c;
  logic              grant_idx_c;
  logic [DATA_W-1:0] grant_data_c;
  logic              accept_c;
  logic              verify_bad_c;

  led_rr_arbiter2 u_rr (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant_any_c (grant_any_c),
    .grant_idx_c (grant_idx_c)
  );

  // Accept handshake is only open in IDLE; the winner sees ready for exactly that cycle.
  assign accept_c     = (state == IDLE) && grant_any_c;
  assign req0_ready   = accept_c && !grant_idx_c;
  assign req1_ready   = accept_c && grant_idx_c;
  assign grant_data_c = grant_idx_c ? req1_data : req0_data;

  // Any upper readback bit set counts as a mismatch, hence the full-width compare.
  assign verify_bad_c = (pio_readdata != PIO_BUS_W'(pattern_q));

  // Only the data register is ever addressed.
  assign pio_address  = LED_ADDR_DATA;

  // Transaction FSM with registered bus strobes, hold counter and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pattern_q       <= '0;
      hold_cnt        <= '0;
      busy            <= 1'b0;
      last_grant      <= 1'b1;
      current_pattern <= '0;
      verify_err      <= 1'b0;
      pio_chipselect  <= 1'b0;
      pio_write_n     <= 1'b1;
      pio_writedata   <= '0;
    end else begin
      if ((state == VERIFY) && verify_bad_c) begin
        verify_err <= 1'b1;
      end else if (err_clear) begin
        verify_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            pattern_q      <= grant_data_c;
            last_grant     <= grant_idx_c;
            busy           <= 1'b1;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= PIO_BUS_W'(grant_data_c);
            state          <= WRITE;
          end
        end
        WRITE: begin
          current_pattern <= pattern_q;
          pio_write_n     <= 1'b1;
          pio_writedata   <= '0;
          state           <= VERIFY;
        end
        VERIFY: begin
          pio_chipselect <= 1'b0;
          hold_cnt       <= CNT_W'(HOLD_CYCLES);
          if (HOLD_CYCLES == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - CNT_W'(1);
          if (hold_cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Directed bench for led_pio_arbiter: one instance with a 3-cycle hold, one with no hold.
module tb_led_pio_arbiter;

  localparam int unsigned DW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (HOLD_CYCLES = 3)
  logic          req0_valid = 1'b0, req1_valid = 1'b0, err_clear = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, pio_chipselect, pio_write_n;
  logic [1:0]    pio_address;
  logic [31:0]   pio_writedata, pio_readdata;
  logic          busy, last_grant, verify_err;
  logic [DW-1:0] current_pattern;
  logic [DW-1:0] pio_reg;
  logic [1:0]    rd_mode = 2'd0;

  // Zero-hold instance
  logic          z_req1_valid = 1'b0;
  logic [DW-1:0] z_req1_data = '0;
  logic          z_req0_ready, z_req1_ready, z_pio_chipselect, z_pio_write_n;
  logic [1:0]    z_pio_address;
  logic [31:0]   z_pio_writedata, z_pio_readdata;
  logic          z_busy, z_last_grant, z_verify_err;
  logic [DW-1:0] z_current_pattern;
  logic [DW-1:0] z_pio_reg;

  led_pio_arbiter #(.DATA_W(DW), .HOLD_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
    .busy(busy), .last_grant(last_grant), .current_pattern(current_pattern),
    .verify_err(verify_err), .err_clear(err_clear)
  );

  led_pio_arbiter #(.DATA_W(DW), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req0_valid(1'b0), .req0_data(5'h00), .req0_ready(z_req0_ready),
    .req1_valid(z_req1_valid), .req1_data(z_req1_data), .req1_ready(z_req1_ready),
    .pio_address(z_pio_address), .pio_chipselect(z_pio_chipselect), .pio_write_n(z_pio_write_n),
    .pio_writedata(z_pio_writedata), .pio_readdata(z_pio_readdata),
    .busy(z_busy), .last_grant(z_last_grant), .current_pattern(z_current_pattern),
    .verify_err(z_verify_err), .err_clear(1'b0)
  );

  // PIO slave models: data register, zero-latency readback, optional corruption
  always @(posedge clk or posedge reset) begin
    if (reset) pio_reg <= '0;
    else if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata[DW-1:0];
  end
  assign pio_readdata = (rd_mode == 2'd1) ? 32'h0 :
                        (rd_mode == 2'd2) ? {1'b1, 26'b0, pio_reg} : {27'b0, pio_reg};

  always @(posedge clk or posedge reset) begin
    if (reset) z_pio_reg <= '0;
    else if (z_pio_chipselect && !z_pio_write_n) z_pio_reg <= z_pio_writedata[DW-1:0];
  end
  assign z_pio_readdata = {27'b0, z_pio_reg};

  // Event monitors, sampled mid-cycle
  int wr_cnt = 0;
  int acc1_cnt = 0;
  int z_acc[$];
  always @(negedge clk) begin
    if (pio_chipselect && !pio_write_n) wr_cnt <= wr_cnt + 1;
    if (req1_valid && req1_ready) acc1_cnt <= acc1_cnt + 1;
    if (z_req1_valid && z_req1_ready) z_acc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag, input int max_cyc, output logic idx, output int at_cyc);
    logic found;
    found = 1'b0;
    idx = 1'b0;
    at_cyc = 0;
    #1;
    for (int i = 0; i < max_cyc; i++) begin
      if (req0_valid && req0_ready) begin found = 1'b1; idx = 1'b0; at_cyc = cyc; break; end
      if (req1_valid && req1_ready) begin found = 1'b1; idx = 1'b1; at_cyc = cyc; break; end
      step();
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) begin found = 1'b1; break; end
      step();
    end
    chk({tag, "_idle"}, 32'(found), 32'd1);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  logic idx;
  int   c0, c1, prev, w0, a0;

  initial begin
    // Reset values
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    chk("rst_pattern", 32'(current_pattern), 32'd0);
    chk("rst_verify_err", 32'(verify_err), 32'd0);
    chk("rst_cs", 32'(pio_chipselect), 32'd0);
    chk("rst_write_n", 32'(pio_write_n), 32'd1);
    chk("rst_wdata", pio_writedata, 32'd0);
    chk("rst_addr", 32'(pio_address), 32'd0);
    reset = 1'b0;
    step();

    // Single requester: write, verify, hold, next accept spacing
    req0_valid = 1'b1; req0_data = 5'h15;
    chk("t1_ready0", 32'(req0_ready), 32'd0);   // combinational ready not settled until wait_accept's #1
    wait_accept("t1a", 10, idx, c0);
    chk("t1_idx", 32'(idx), 32'd0);
    chk("t1_ready1_low", 32'(req1_ready), 32'd0);
    step();
    chk("t1_w_cs", 32'(pio_chipselect), 32'd1);
    chk("t1_w_wn", 32'(pio_write_n), 32'd0);
    chk("t1_w_data", pio_writedata, 32'h15);
    chk("t1_w_addr", 32'(pio_address), 32'd0);
    chk("t1_w_busy", 32'(busy), 32'd1);
    chk("t1_w_lg", 32'(last_grant), 32'd0);
    chk("t1_w_rdy", 32'(req0_ready), 32'd0);
    req0_data = 5'h0A;
    step();
    chk("t1_v_cs", 32'(pio_chipselect), 32'd1);
    chk("t1_v_wn", 32'(pio_write_n), 32'd1);
    chk("t1_v_wdata", pio_writedata, 32'd0);
    chk("t1_v_pat", 32'(current_pattern), 32'h15);
    chk("t1_pio_out", 32'(pio_reg), 32'h15);
    step();
    chk("t1_h_err", 32'(verify_err), 32'd0);
    chk("t1_h_cs", 32'(pio_chipselect), 32'd0);
    chk("t1_h_busy", 32'(busy), 32'd1);
    wait_accept("t1b", 20, idx, c1);
    chk("t1_spacing", 32'(c1 - c0), 32'd6);
    step();
    req0_valid = 1'b0;
    chk("t1b_wdata", pio_writedata, 32'h0A);
    wait_idle("t1", 20);

    // Both valid: strict alternation starting at requester 0
    reset = 1'b1; step(); reset = 1'b0; step();
    req0_valid = 1'b1; req0_data = 5'h01;
    req1_valid = 1'b1; req1_data = 5'h1E;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accept("t2", 20, idx, c1);
      chk("t2_idx", 32'(idx), 32'(i % 2));
      if (i > 0) chk("t2_spacing", 32'(c1 - prev), 32'd6);
      prev = c1;
      step(); step();
      chk("t2_pat", 32'(current_pattern), (i % 2 == 1) ? 32'h1E : 32'h01);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("t2", 20);

    // Read-back mismatch, sticky flag, clear, set-wins-over-clear, upper bits
    rd_mode = 2'd1;
    req0_valid = 1'b1; req0_data = 5'h1F;
    wait_accept("t3a", 10, idx, c0);
    step(); req0_valid = 1'b0;
    step(); step();
    chk("t3_err_set", 32'(verify_err), 32'd1);
    rd_mode = 2'd0;
    wait_idle("t3a", 20);
    step(); step();
    chk("t3_err_sticky", 32'(verify_err), 32'd1);
    clear_err();
    chk("t3_err_cleared", 32'(verify_err), 32'd0);
    rd_mode = 2'd1;
    req1_valid = 1'b1; req1_data = 5'h1F;
    wait_accept("t3b", 10, idx, c0);
    step(); req1_valid = 1'b0; err_clear = 1'b1;
    step(); step(); err_clear = 1'b0;
    chk("t3_set_wins", 32'(verify_err), 32'd1);
    rd_mode = 2'd0;
    wait_idle("t3b", 20);
    clear_err();
    chk("t3_err_cleared2", 32'(verify_err), 32'd0);
    rd_mode = 2'd2;
    req0_valid = 1'b1; req0_data = 5'h05;
    wait_accept("t3c", 10, idx, c0);
    step(); req0_valid = 1'b0;
    step(); step();
    chk("t3_upper_bits", 32'(verify_err), 32'd1);
    rd_mode = 2'd0;
    wait_idle("t3c", 20);
    clear_err();

    // Zero-hold build: accepts every 3 cycles
    z_req1_valid = 1'b1; z_req1_data = 5'h07;
    for (int i = 0; i < 12; i++) step();
    z_req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t4_z_count_ok", 32'(z_acc.size() >= 3), 32'd1);
    for (int i = 1; i < z_acc.size(); i++) chk("t4_z_spacing", 32'(z_acc[i] - z_acc[i-1]), 32'd3);
    chk("t4_z_pio", 32'(z_pio_reg), 32'h07);
    chk("t4_z_busy", 32'(z_busy), 32'd0);

    // Reset during HOLD, then a normal transaction
    req1_valid = 1'b1; req1_data = 5'h12;
    wait_accept("t5a", 10, idx, c0);
    step(); req1_valid = 1'b0;
    step(); step();
    chk("t5_in_hold", 32'(busy), 32'd1);
    reset = 1'b1; #1;
    chk("t5h_busy", 32'(busy), 32'd0);
    chk("t5h_cs", 32'(pio_chipselect), 32'd0);
    chk("t5h_wn", 32'(pio_write_n), 32'd1);
    chk("t5h_lg", 32'(last_grant), 32'd1);
    chk("t5h_pat", 32'(current_pattern), 32'd0);
    step(); reset = 1'b0;
    req0_valid = 1'b1; req0_data = 5'h0C;
    wait_accept("t5b", 10, idx, c0);
    chk("t5b_idx", 32'(idx), 32'd0);
    step();
    chk("t5b_wdata", pio_writedata, 32'h0C);
    chk("t5b_wn", 32'(pio_write_n), 32'd0);
    req0_valid = 1'b0;
    step(); step();
    chk("t5b_pat", 32'(current_pattern), 32'h0C);
    wait_idle("t5b", 20);

    // Reset during WRITE, then the same requester is served cleanly
    req1_valid = 1'b1; req1_data = 5'h09;
    wait_accept("t5c", 10, idx, c0);
    step();
    chk("t5w_in_write", 32'(pio_write_n), 32'd0);
    reset = 1'b1; #1;
    chk("t5w_busy", 32'(busy), 32'd0);
    chk("t5w_cs", 32'(pio_chipselect), 32'd0);
    chk("t5w_wn", 32'(pio_write_n), 32'd1);
    chk("t5w_wdata", pio_writedata, 32'd0);
    chk("t5w_lg", 32'(last_grant), 32'd1);
    step(); reset = 1'b0;
    wait_accept("t5d", 10, idx, c0);
    chk("t5d_idx", 32'(idx), 32'd1);
    step();
    chk("t5d_wdata", pio_writedata, 32'h09);
    req1_valid = 1'b0;
    wait_idle("t5d", 20);
    chk("t5d_pio", 32'(pio_reg), 32'h09);

    // Requester 1 valid only while holding: never accepted, no bus traffic
    req0_valid = 1'b1; req0_data = 5'h11;
    wait_accept("t6", 10, idx, c0);
    step(); req0_valid = 1'b0;
    step(); step();
    w0 = wr_cnt; a0 = acc1_cnt;
    req1_valid = 1'b1; req1_data = 5'h1A;
    #1;
    chk("t6_ready_hold", 32'(req1_ready), 32'd0);
    step(); step();
    req1_valid = 1'b0;
    step();
    chk("t6_busy_drop", 32'(busy), 32'd0);
    step(); step();
    chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("t6_no_accept", 32'(acc1_cnt - a0), 32'd0);
    chk("t6_pat", 32'(current_pattern), 32'h11);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pio_arbiter.md
Name: led_pio_arbiter

Overview:
- Avalon-MM master that shares the 5-bit LED PIO slave between two pattern requesters (e.g. Nios-side software mailbox and a hardware status blinker).
- Round-robin grant, one PIO write per transaction, read-back verify, then minimum display hold before the next grant.
- Sits between the requesters and the LED PIO s1 port; the PIO's out_port drives the board LEDs unchanged.

Parameters:
- DATA_W, 5, LED pattern width (PIO data width)
- HOLD_CYCLES, 1000, minimum clk cycles a granted pattern stays displayed before the next grant; 0 legal
- CNT_W, $clog2(HOLD_CYCLES+1) (min 1), hold counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a pattern
- req0_data  in  DATA_W  requester 0 pattern
- req0_ready  out  1  requester 0 pattern accepted this cycle (valid&&ready)
- req1_valid  in  1  requester 1 has a pattern
- req1_data  in  DATA_W  requester 1 pattern
- req1_ready  out  1  requester 1 pattern accepted this cycle
- pio_address  out  2  PIO register address, always 0
- pio_chipselect  out  1  PIO chipselect
- pio_write_n  out  1  PIO write strobe, active-low
- pio_writedata  out  32  zero-extended pattern
- pio_readdata  in  32  PIO read data, zero-latency (combinational in slave)
- busy  out  1  state != IDLE
- last_grant  out  1  index of most recent granted requester
- current_pattern  out  DATA_W  last pattern written
- verify_err  out  1  sticky read-back mismatch flag
- err_clear  in  1  clears verify_err

Behaviour:
- Reset (async): state=IDLE, last_grant=1, current_pattern=0, verify_err=0, hold counter=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, pio_address=0, both ready=0.
- FSM: IDLE -> WRITE -> VERIFY -> HOLD -> IDLE.
- IDLE: grant computed combinationally. Only one valid: grant it. Both valid: grant !last_grant. Granted readyN=1 this cycle only; other ready=0; no valid: stay IDLE, readys 0. On accept: latch data into pattern reg, last_grant<=N, -> WRITE.
- readyN is 0 in every state except IDLE; valid deasserting in IDLE never causes an accept.
- WRITE (1 cycle): chipselect=1, write_n=0, address=0, writedata={27'b0,pattern}; current_pattern<=pattern; -> VERIFY.
- VERIFY (1 cycle): chipselect=1, write_n=1, address=0; compare pio_readdata[DATA_W-1:0] to pattern; mismatch or nonzero upper bits -> verify_err<=1. Load counter with HOLD_CYCLES; HOLD_CYCLES==0 -> IDLE, else -> HOLD.
- HOLD: chipselect=0, write_n=1; counter decrements each cycle; at counter==1 -> IDLE. Exactly HOLD_CYCLES cycles in HOLD.
- Latency: accept at cycle T, write at T+1, verify at T+2, earliest next accept T+3+HOLD_CYCLES.
- verify_err: err_clear sets 0; simultaneous mismatch and err_clear -> set wins.
- Requester data changing after accept has no effect on the in-flight transaction.
- Reset asserted in any state: immediate return to reset values; in-flight pattern dropped; PIO holds whatever its own reset gives.
- pio_writedata driven 0 outside WRITE.

Decomposition:
- Shared package led_pio_pkg: state enum (IDLE, WRITE, VERIFY, HOLD), LED_ADDR_DATA=2'd0, LED_DATA_W=5.
- One sub-module natural: led_rr_arbiter2 (2-way round-robin grant from valids + last_grant, combinational); FSM, counter and bus drive stay in top.

Test Plan:
- Reset then req0_valid=1, req0_data=5'h15 -> req0_ready pulse at T, write of 32'h15 at T+1, PIO out_port=5'h15, verify_err=0, next accept no earlier than T+3+HOLD_CYCLES.
- Both valid continuously, req0=5'h01, req1=5'h1E -> grants alternate 0,1,0,1 starting with 0; current_pattern alternates 01/1E.
- Force pio_readdata=5'h00 during VERIFY for pattern 5'h1F -> verify_err=1 and stays 1; err_clear pulse -> 0; err_clear same cycle as mismatch -> 1.
- HOLD_CYCLES=0 build, req1 held valid -> accepts every 3 cycles; HOLD_CYCLES=3 -> every 6 cycles.
- Assert reset during HOLD and during WRITE -> busy=0, chipselect=0, write_n=1, last_grant=1 same cycle; next transaction proceeds normally.
- req1_valid pulsed only during HOLD -> never accepted, no PIO access, busy drops back to 0 after hold.
